// File: rtl/rsa_pkg.sv
// Shared types, default parameters and helpers for the RSA multi-channel controller.
package rsa_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_TMO_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2, minimum 1 so a select bus is never zero width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_mc_ctrl_if.sv
// Control/result link between the controller and the shared RSA core.
interface rsa_mc_ctrl_if #(
  parameter int unsigned NUM_CH = rsa_pkg::DEF_NUM_CH,
  parameter int unsigned WIDTH  = rsa_pkg::DEF_WIDTH
);
  localparam int unsigned SEL_W = rsa_pkg::clog2(NUM_CH);

  logic             core_en;
  logic             core_rstb;
  logic [SEL_W-1:0] core_sel;
  logic             core_eoc;
  logic [WIDTH-1:0] core_c;

  modport master (
    output core_en, core_rstb, core_sel,
    input  core_eoc, core_c
  );

  modport slave (
    input  core_en, core_rstb, core_sel,
    output core_eoc, core_c
  );
endinterface

// File: rtl/rsa_mc_ctrl_rr_arbiter.sv
// Round-robin pick of one pending channel, searching upward from ptr.
module rr_arbiter import rsa_pkg::*; #(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned SEL_W = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);

  // First requesting channel at or after ptr, wrapping modulo NUM_CH.
  always_comb begin
    int unsigned c;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = (32'(ptr) + i) % NUM_CH;
      if (!found && req[SEL_W'(c)]) begin
        found              = 1'b1;
        gnt[SEL_W'(c)]     = 1'b1;
        idx                = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/rsa_mc_ctrl.sv
// Multi-channel job controller sharing one RSA core between NUM_CH requesters.
module rsa_mc_ctrl import rsa_pkg::*; #(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned TMO_W  = DEF_TMO_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [NUM_CH-1:0]       start,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       irq_mask,
  input  logic [NUM_CH-1:0]       irq_clr,
  input  logic [TMO_W-1:0]        tmo_cycles,
  rsa_mc_ctrl_if.master           core,
  output logic [NUM_CH*WIDTH-1:0] result,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err,
  output logic                    busy,
  output logic                    irq
);

  localparam int unsigned SEL_W = clog2(NUM_CH);

  state_t             state, state_n;
  logic [NUM_CH-1:0]  pending, pend_n;
  logic [NUM_CH-1:0]  done_n, err_n;
  logic [WIDTH-1:0]   res_r [NUM_CH];
  logic [WIDTH-1:0]   res_n [NUM_CH];
  logic [SEL_W-1:0]   rr_ptr, rr_n;
  logic [SEL_W-1:0]   sel_r, sel_n;
  logic [TMO_W-1:0]   cnt, cnt_n;
  logic               core_en_r, core_en_n;
  logic               core_rstb_r, core_rstb_n;
  logic               busy_n, irq_n;
  logic [NUM_CH-1:0]  accept;
  logic               tmo_hit;
  logic [NUM_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0]   arb_idx;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (pending),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign tmo_hit = (tmo_cycles != '0) && (cnt == tmo_cycles - TMO_W'(1));

  // Next-state, per-channel flag and registered-output computation.
  always_comb begin
    state_n     = state;
    pend_n      = pending;
    done_n      = done;
    err_n       = err;
    res_n       = res_r;
    rr_n        = rr_ptr;
    sel_n       = sel_r;
    cnt_n       = cnt;
    accept      = '0;

    // Clears first so that a same-cycle set below takes priority.
    done_n = done_n & ~irq_clr;
    err_n  = err_n & ~irq_clr;

    if (stop) begin
      pend_n  = '0;
      state_n = IDLE;
    end else begin
      // The granted channel stays pending until it finishes, so this also blocks restarts of it.
      accept = start & ~pending;
      pend_n = pend_n | accept;
      done_n = done_n & ~accept;
      err_n  = err_n & ~accept;

      if (ena) begin
        case (state)
          IDLE: begin
            if (|arb_gnt) begin
              sel_n   = arb_idx;
              rr_n    = SEL_W'((32'(arb_idx) + 1) % NUM_CH);
              state_n = CLEAR;
            end
          end
          CLEAR: begin
            cnt_n   = '0;
            state_n = RUN;
          end
          RUN: begin
            if (core.core_eoc) begin
              res_n[sel_r]  = core.core_c;
              done_n[sel_r] = 1'b1;
              pend_n[sel_r] = 1'b0;
              state_n       = DONE;
            end else if (tmo_hit) begin
              err_n[sel_r]  = 1'b1;
              pend_n[sel_r] = 1'b0;
              state_n       = DONE;
            end else begin
              cnt_n = cnt + TMO_W'(1);
            end
          end
          DONE: state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end

    core_en_n   = (state_n == RUN) && ena;
    core_rstb_n = (state_n != CLEAR);
    busy_n      = (state_n != IDLE);
    irq_n       = |((done | err) & ~irq_mask);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      done        <= '0;
      err         <= '0;
      res_r       <= '{default: '0};
      rr_ptr      <= '0;
      sel_r       <= '0;
      cnt         <= '0;
      core_en_r   <= 1'b0;
      core_rstb_r <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pend_n;
      done        <= done_n;
      err         <= err_n;
      res_r       <= res_n;
      rr_ptr      <= rr_n;
      sel_r       <= sel_n;
      cnt         <= cnt_n;
      core_en_r   <= core_en_n;
      core_rstb_r <= core_rstb_n;
      busy        <= busy_n;
      irq         <= irq_n;
    end
  end

  assign core.core_en   = core_en_r;
  assign core.core_rstb = core_rstb_r;
  assign core.core_sel  = sel_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_res
    assign result[g*WIDTH +: WIDTH] = res_r[g];
  end

endmodule
